// File: rtl/regfile_write_scheduler_pkg.sv
// Shared sizing constants and writeback source encoding for the register file
// write scheduler.
package regfile_write_scheduler_pkg;

  localparam int NREG = 64;
  localparam int AW   = 6;
  localparam int DW   = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_write_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins at once; on contention the
// source favoured by ptr wins, and ptr moves to the other source after any grant.
module rr_arb2
  import regfile_write_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output wb_src_e    ptr
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr == SRC_ALU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // ptr holds the favoured source; it only moves when something is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= SRC_ALU;
    end else if (grant[0]) begin
      ptr <= SRC_MEM;
    end else if (grant[1]) begin
      ptr <= SRC_ALU;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Issue-side scoreboard plus a two-source writeback scheduler driving a single
// registered register file write port.
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int NREG = regfile_write_scheduler_pkg::NREG,
  parameter int AW   = regfile_write_scheduler_pkg::AW,
  parameter int DW   = regfile_write_scheduler_pkg::DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_Rs,
  input  logic [AW-1:0]   iss_Rt,
  input  logic [AW-1:0]   iss_Rd,
  input  logic            iss_wr,
  output logic            iss_stall,
  input  logic            wb0_valid,
  input  logic [AW-1:0]   wb0_Rd,
  input  logic [DW-1:0]   wb0_data,
  input  logic            wb1_valid,
  input  logic [AW-1:0]   wb1_Rd,
  input  logic [DW-1:0]   wb1_data,
  output logic            wb0_ready,
  output logic            wb1_ready,
  output logic            wrt,
  output logic [AW-1:0]   Rd,
  output logic [DW-1:0]   data_in,
  output logic [NREG-1:0] busy,
  output logic            wb_err,
  output wb_src_e         arb_ptr
);

  // Handshake: a writeback transfers on any cycle where valid && ready; ready is
  // combinational from both valids and the arbiter pointer, never more than one
  // high, and a requester must hold valid and its payload until it sees ready.

  logic [1:0]      grant;
  logic            gnt_any;
  logic [AW-1:0]   gnt_rd;
  logic [DW-1:0]   gnt_data;
  logic            iss_accept;
  logic [NREG-1:0] busy_next;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({wb1_valid, wb0_valid}),
    .grant (grant),
    .ptr   (arb_ptr)
  );

  assign wb0_ready = grant[0];
  assign wb1_ready = grant[1];
  assign gnt_any   = |grant;
  assign gnt_rd    = grant[1] ? wb1_Rd : wb0_Rd;
  assign gnt_data  = grant[1] ? wb1_data : wb0_data;

  // Stall looks only at registered busy, so a clear this cycle is seen next cycle.
  assign iss_stall  = iss_valid & (busy[iss_Rs] | busy[iss_Rt] | (iss_wr & busy[iss_Rd]));
  assign iss_accept = iss_valid & ~iss_stall;

  // Clear first, then set, so a same-cycle set of the same register wins.
  always_comb begin
    busy_next = busy;
    if (gnt_any) begin
      busy_next[gnt_rd] = 1'b0;
    end
    if (iss_accept && iss_wr) begin
      busy_next[iss_Rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= '0;
      wrt     <= 1'b0;
      Rd      <= '0;
      data_in <= '0;
      wb_err  <= 1'b0;
    end else begin
      busy <= busy_next;
      wrt  <= gnt_any;
      if (gnt_any) begin
        Rd      <= gnt_rd;
        data_in <= gnt_data;
        if (!busy[gnt_rd]) begin
          wb_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler with a write-port scoreboard.
module tb_regfile_write_scheduler;
  import regfile_write_scheduler_pkg::*;

  logic            clk;
  logic            rst;
  logic            iss_valid;
  logic [AW-1:0]   iss_Rs;
  logic [AW-1:0]   iss_Rt;
  logic [AW-1:0]   iss_Rd;
  logic            iss_wr;
  logic            iss_stall;
  logic            wb0_valid;
  logic [AW-1:0]   wb0_Rd;
  logic [DW-1:0]   wb0_data;
  logic            wb1_valid;
  logic [AW-1:0]   wb1_Rd;
  logic [DW-1:0]   wb1_data;
  logic            wb0_ready;
  logic            wb1_ready;
  logic            wrt;
  logic [AW-1:0]   Rd;
  logic [DW-1:0]   data_in;
  logic [NREG-1:0] busy;
  logic            wb_err;
  wb_src_e         arb_ptr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+DW-1:0] exp_q[$];

  regfile_write_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_Rs    (iss_Rs),
    .iss_Rt    (iss_Rt),
    .iss_Rd    (iss_Rd),
    .iss_wr    (iss_wr),
    .iss_stall (iss_stall),
    .wb0_valid (wb0_valid),
    .wb0_Rd    (wb0_Rd),
    .wb0_data  (wb0_data),
    .wb1_valid (wb1_valid),
    .wb1_Rd    (wb1_Rd),
    .wb1_data  (wb1_data),
    .wb0_ready (wb0_ready),
    .wb1_ready (wb1_ready),
    .wrt       (wrt),
    .Rd        (Rd),
    .data_in   (data_in),
    .busy      (busy),
    .wb_err    (wb_err),
    .arb_ptr   (arb_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_Rs = '0; iss_Rt = '0; iss_Rd = '0; iss_wr = 1'b0;
    wb0_valid = 1'b0; wb0_Rd = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_Rd = '0; wb1_data = '0;
  endtask

  task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic wr);
    iss_valid = 1'b1; iss_Rs = rs; iss_Rt = rt; iss_Rd = rd; iss_wr = wr;
  endtask

  task automatic drive_wb0(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    wb0_valid = 1'b1; wb0_Rd = rd; wb0_data = d;
  endtask

  task automatic drive_wb1(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    wb1_valid = 1'b1; wb1_Rd = rd; wb1_data = d;
  endtask

  task automatic expect_write(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    exp_q.push_back({rd, d});
  endtask

  // scoreboard: every write-port pulse must match the oldest expected write
  always @(negedge clk) begin
    if (wrt === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 64'(wrt), 64'd0);
      end else begin
        check("wr_port", 64'({Rd, data_in}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_busy", busy, 64'd0);
    check("rst_wrt", 64'(wrt), 64'd0);
    check("rst_rd", 64'(Rd), 64'd0);
    check("rst_data", 64'(data_in), 64'd0);
    check("rst_err", 64'(wb_err), 64'd0);
    check("rst_ptr", 64'(arb_ptr), 64'(SRC_ALU));
    rst = 1'b0;

    // non-writing issue with clean scoreboard
    issue(6'd3, 6'd4, 6'd9, 1'b0);
    #1 check("nowr_stall", 64'(iss_stall), 64'd0);
    step();
    check("nowr_busy", busy, 64'd0);

    // RAW hazard on r21 resolved by an ALU writeback
    issue(6'd0, 6'd0, 6'd21, 1'b1);
    #1 check("raw_prod_stall", 64'(iss_stall), 64'd0);
    step();
    check("raw_busy21", busy, 64'h0000_0000_0020_0000);
    issue(6'd21, 6'd0, 6'd0, 1'b0);
    #1 check("raw_stall_a", 64'(iss_stall), 64'd1);
    step();
    check("raw_stall_b", 64'(iss_stall), 64'd1);
    drive_wb0(6'd21, 32'd5);
    #1 check("raw_wb0_ready", 64'(wb0_ready), 64'd1);
    check("raw_wb1_ready", 64'(wb1_ready), 64'd0);
    check("raw_no_bypass", 64'(iss_stall), 64'd1);
    expect_write(6'd21, 32'd5);
    step();
    wb0_valid = 1'b0;
    #1 check("raw_wrt", 64'(wrt), 64'd1);
    check("raw_rd", 64'(Rd), 64'd21);
    check("raw_data", 64'(data_in), 64'd5);
    check("raw_busy_clr", busy, 64'd0);
    check("raw_issue_ok", 64'(iss_stall), 64'd0);
    check("raw_ptr", 64'(arb_ptr), 64'(SRC_MEM));
    step();
    idle_inputs();
    check("raw_wrt_drop", 64'(wrt), 64'd0);

    // same-cycle set and clear of r7: set wins; r7 was idle so wb_err fires
    issue(6'd0, 6'd0, 6'd7, 1'b1);
    drive_wb1(6'd7, 32'h77);
    #1 check("sc_wb1_ready", 64'(wb1_ready), 64'd1);
    check("sc_stall", 64'(iss_stall), 64'd0);
    expect_write(6'd7, 32'h77);
    step();
    idle_inputs();
    check("sc_busy7", busy, 64'h0000_0000_0000_0080);
    check("sc_err", 64'(wb_err), 64'd1);

    // reset mid-operation with r5 busy and a load writeback pending
    issue(6'd0, 6'd0, 6'd5, 1'b1);
    drive_wb0(6'd7, 32'h17);
    expect_write(6'd7, 32'h17);
    step();
    idle_inputs();
    check("mr_busy5", busy, 64'h0000_0000_0000_0020);
    check("mr_ptr_pre", 64'(arb_ptr), 64'(SRC_MEM));
    rst = 1'b1;
    drive_wb1(6'd5, 32'h55);
    #1 check("mr_ready_comb", 64'(wb1_ready), 64'd1);
    step();
    rst = 1'b0;
    idle_inputs();
    check("mr_busy", busy, 64'd0);
    check("mr_wrt", 64'(wrt), 64'd0);
    check("mr_err", 64'(wb_err), 64'd0);
    check("mr_ptr", 64'(arb_ptr), 64'(SRC_ALU));

    // both sources contend for 4 cycles: grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      drive_wb0(6'd20, 32'h100 + 32'(i));
      drive_wb1(6'd21, 32'h200 + 32'(i));
      #1;
      if (i % 2 == 0) begin
        check("rr_ready0", 64'(wb0_ready), 64'd1);
        check("rr_ready1", 64'(wb1_ready), 64'd0);
        expect_write(6'd20, 32'h100 + 32'(i));
      end else begin
        check("rr_ready0", 64'(wb0_ready), 64'd0);
        check("rr_ready1", 64'(wb1_ready), 64'd1);
        expect_write(6'd21, 32'h200 + 32'(i));
      end
      step();
      check("rr_wrt", 64'(wrt), 64'd1);
    end
    idle_inputs();
    step();
    check("rr_wrt_end", 64'(wrt), 64'd0);
    check("rr_ptr_hold", 64'(arb_ptr), 64'(SRC_ALU));

    // lone load grant, idle cycle, then contention favours ALU
    drive_wb1(6'd9, 32'h99);
    #1 check("lone_ready1", 64'(wb1_ready), 64'd1);
    expect_write(6'd9, 32'h99);
    step();
    idle_inputs();
    step();
    check("idle_ptr", 64'(arb_ptr), 64'(SRC_ALU));
    drive_wb0(6'd10, 32'hA0);
    drive_wb1(6'd11, 32'hB0);
    #1 check("ct_ready0", 64'(wb0_ready), 64'd1);
    check("ct_ready1", 64'(wb1_ready), 64'd0);
    expect_write(6'd10, 32'hA0);
    step();
    wb0_valid = 1'b0;
    #1 check("ct_wait_ready1", 64'(wb1_ready), 64'd1);
    expect_write(6'd11, 32'hB0);
    step();
    idle_inputs();
    step();

    // stray writeback to idle r30 sets sticky wb_err
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("err_clear", 64'(wb_err), 64'd0);
    drive_wb0(6'd30, 32'h30);
    #1 check("err_ready0", 64'(wb0_ready), 64'd1);
    expect_write(6'd30, 32'h30);
    step();
    idle_inputs();
    check("err_set", 64'(wb_err), 64'd1);
    check("err_wrt", 64'(wrt), 64'd1);
    check("err_rd", 64'(Rd), 64'd30);
    for (int k = 0; k < 3; k++) step();
    check("err_sticky", 64'(wb_err), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("err_rst", 64'(wb_err), 64'd0);
    step();

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
